// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one input bit per clock. Feeds the per-digit 7-segment decoders.
//
// Parameters
//   IN_WIDTH : width of the binary input (>= 1)
//   DIGITS   : number of BCD output digits (>= 1)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : conversion request, only looked at while idle
//   bin_in     : binary value, captured on the edge that accepts start
//   busy       : high while a conversion is in progress
//   done       : one-cycle pulse when bcd_out/overflow/blank_mask update
//   bcd_out    : packed BCD result, digit 0 in bits [3:0]; all nines on overflow
//   overflow   : value did not fit in DIGITS decimal digits
//   blank_mask : leading-zero flag per digit (bit 0 always 0)
//
// Handshake: start is accepted on a rising edge where the block is idle
// (busy=0). From then on start and bin_in are ignored until the result is
// published; done pulses for exactly the cycle following the last shift, and
// the outputs hold their value until the next done pulse.
//
// Configuration
//   BCD_LEADING_BLANK_EN : when defined, blank_mask is registered alongside
//                          bcd_out; otherwise blank_mask is constant zero.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [BW-1:0]         scr_q, scr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  oflow_q, oflow_d;

  // One double-dabble step computed from the current scratch/binary pair.
  logic [BW-1:0]         adj;
  logic [BW-1:0]         scr_next;
  logic [IN_WIDTH-1:0]   bin_next;
  logic                  ovf_next;
  logic                  last_shift;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      // Each nibble is corrected on its own; a nibble of 5..9 becomes 8..12,
      // which still fits in 4 bits, so no carry crosses into its neighbour.
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      else                         adj[4*i +: 4] = scr_q[4*i +: 4];
    end
    if (BW > 1) scr_next = {adj[BW-2:0], bin_q[IN_WIDTH-1]};
    else        scr_next = bin_q[IN_WIDTH-1];
    bin_next   = bin_q << 1;
    // Any bit leaving the top digit means the value needs more digits.
    ovf_next   = ovf_q | adj[BW-1];
    last_shift = (state_q == SHIFT) && (cnt_q == CW'(1));
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    oflow_d = oflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(IN_WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_next;
        scr_d = scr_next;
        ovf_d = ovf_next;
        cnt_d = cnt_q - CW'(1);
        if (last_shift) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = ovf_next ? {DIGITS{4'h9}} : scr_next;
          oflow_d = ovf_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      oflow_q <= oflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = oflow_q;

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;

  // Digit i is blanked when it and every more significant digit are zero.
  // Digit 0 is never blanked so a zero result still shows a single "0".
  always_comb begin
    blank_d    = blank_q;
    zero_above = 1'b1;
    if (last_shift) begin
      blank_d = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above & (scr_next[4*i +: 4] == 4'd0);
        blank_d[i] = zero_above & ~ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic [7:0]  bin_in;
  logic        busy, done, overflow;
  logic [11:0] bcd_out;
  logic [2:0]  blank_mask;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd_out2;
  logic [1:0]  blank_mask2;

  bin_to_bcd_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
    .blank_mask(blank_mask)
  );

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2),
    .blank_mask(blank_mask2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the integer value.
  task automatic model(input int v, input int d, output logic [11:0] bcd,
                       output logic ovf, output logic [2:0] blank);
    int lim;
    int p;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf   = (v >= lim);
    bcd   = '0;
    blank = '0;
    p     = 1;
    for (int i = 0; i < d; i++) begin
      bcd[4*i +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
      if (i >= 1) blank[i] = !ovf && (v < p);
      p = p * 10;
    end
`ifndef BCD_LEADING_BLANK_EN
    blank = '0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge right after the accepting edge.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Entered lat0 cycles after the accept edge; returns at the negedge where
  // done is high (or after the cycle budget expires).
  task automatic wait_done(input string nm, input int lat0);
    int lat;
    int busy_cnt;
    logic [11:0] held;
    logic [7:0]  held2;
    logic        held_ok;
    lat = lat0; busy_cnt = 0; held = bcd_out; held2 = bcd_out2; held_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (bcd_out !== held || bcd_out2 !== held2) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_busy_cycles"}, busy_cnt, 8 - lat0);
    chk({nm, "_hold_while_busy"}, held_ok, 1);
    chk({nm, "_done2_sync"}, done2, 1);
    chk({nm, "_busy_at_done"}, {busy, busy2}, 0);
  endtask

  task automatic check_out(input string nm, input logic [11:0] e_bcd, input logic e_ovf,
                           input logic [2:0] e_blank, input logic [7:0] e2_bcd,
                           input logic e2_ovf, input logic [1:0] e2_blank);
    logic [2:0] b1;
    logic [1:0] b2;
    b1 = e_blank; b2 = e2_blank;
`ifndef BCD_LEADING_BLANK_EN
    b1 = '0; b2 = '0;
`endif
    chk({nm, "_bcd"}, bcd_out, e_bcd);
    chk({nm, "_ovf"}, overflow, e_ovf);
    chk({nm, "_blank"}, blank_mask, b1);
    chk({nm, "_bcd_d2"}, bcd_out2, e2_bcd);
    chk({nm, "_ovf_d2"}, overflow2, e2_ovf);
    chk({nm, "_blank_d2"}, blank_mask2, b2);
  endtask

  task automatic pulse_end(input string nm);
    @(negedge clk);
    chk({nm, "_done_single"}, {done, done2}, 0);
    chk({nm, "_idle_after"}, {busy, busy2}, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic [1:0]  blank2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [11:0] m_bcd, m2_bcd;
    logic        m_ovf, m2_ovf;
    logic [2:0]  m_blank, m2_blank;
    int          times[3];
    int          n, t;
    logic        quiet;

    tbl[0] = '{8'd0,   12'h000, 1'b0, 3'b110, 8'h00, 1'b0, 2'b10};
    tbl[1] = '{8'd255, 12'h255, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00};
    tbl[2] = '{8'd99,  12'h099, 1'b0, 3'b100, 8'h99, 1'b0, 2'b00};
    tbl[3] = '{8'd128, 12'h128, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00};
    tbl[4] = '{8'd7,   12'h007, 1'b0, 3'b110, 8'h07, 1'b0, 2'b10};
    tbl[5] = '{8'd40,  12'h040, 1'b0, 3'b100, 8'h40, 1'b0, 2'b00};
    tbl[6] = '{8'd205, 12'h205, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00};
    tbl[7] = '{8'd200, 12'h200, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00};
    tbl[8] = '{8'd100, 12'h100, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00};
    tbl[9] = '{8'd10,  12'h010, 1'b0, 3'b100, 8'h10, 1'b0, 2'b00};

    // reset state
    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {busy, busy2}, 0);
    chk("reset_done", {done, done2}, 0);
    chk("reset_bcd", {bcd_out, bcd_out2}, 0);
    chk("reset_ovf", {overflow, overflow2}, 0);
    chk("reset_blank", {blank_mask, blank_mask2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven conversions
    for (int i = 0; i < 10; i++) begin
      accept(tbl[i].bin);
      wait_done($sformatf("tbl%0d", i), 0);
      check_out($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].ovf, tbl[i].blank,
                tbl[i].bcd2, tbl[i].ovf2, tbl[i].blank2);
      pulse_end($sformatf("tbl%0d", i));
    end

    // start re-pulsed and bin_in changed while busy: ignored
    accept(8'd173);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; bin_in = 8'd42;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 3);
    check_out("busy_start", 12'h173, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00);
    pulse_end("busy_start");
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) quiet = 1'b0;
    end
    chk("busy_start_no_relaunch", quiet, 1);

    // start held high: a new conversion every IN_WIDTH+1 cycles
    @(negedge clk);
    start = 1'b1; bin_in = 8'd50;
    times = '{0, 0, 0}; n = 0; t = 0;
    while (n < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        times[n] = t;
        n++;
      end
    end
    start = 1'b0;
    chk("held_done_count", n, 3);
    chk("held_first_latency", times[0], 9);
    chk("held_period_a", times[1] - times[0], 9);
    chk("held_period_b", times[2] - times[1], 9);
    check_out("held", 12'h050, 1'b0, 3'b100, 8'h50, 1'b0, 2'b00);
    pulse_end("held");

    // asynchronous reset mid-conversion
    accept(8'd200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {busy, busy2}, 0);
    chk("midrst_done", {done, done2}, 0);
    chk("midrst_bcd", {bcd_out, bcd_out2}, 0);
    chk("midrst_ovf", {overflow, overflow2}, 0);
    chk("midrst_blank", {blank_mask, blank_mask2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(8'd17);
    wait_done("after_rst", 0);
    check_out("after_rst", 12'h017, 1'b0, 3'b100, 8'h17, 1'b0, 2'b00);
    pulse_end("after_rst");

    // randomized values against the reference model
    for (int k = 0; k < 25; k++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      model(int'(v), 3, m_bcd, m_ovf, m_blank);
      model(int'(v), 2, m2_bcd, m2_ovf, m2_blank);
      accept(v);
      wait_done($sformatf("rnd%0d_v%0d", k, v), 0);
      check_out($sformatf("rnd%0d_v%0d", k, v), m_bcd, m_ovf, m_blank,
                m2_bcd[7:0], m2_ovf, m2_blank[1:0]);
      if ($urandom_range(0, 1) == 1) pulse_end($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
